// File: rtl/cm3_reset_seq.sv
// Reset controller: merges POR, external pin, SYSRESETREQ, software and optional watchdog
// requests into an ordered release of NUM_DOMAINS resets. Watchdog built when CM3_RST_WDT_EN is defined.
module cm3_reset_seq #(
   parameter int NUM_DOMAINS = 2,
   parameter int STRETCH     = 15,
   parameter int SYNC_STAGES = 2,
   parameter int WDT_WIDTH   = 16
) (
   input  logic                   CLK,
   input  logic                   PORESET,
   input  logic                   EXT_RESETn,
   input  logic                   SYSRESETREQ,
   input  logic                   SWRESET_REQ,
   input  logic                   CAUSE_CLR,
`ifdef CM3_RST_WDT_EN
   input  logic                   WDT_EN,
   input  logic                   WDT_KICK,
   input  logic [WDT_WIDTH-1:0]   WDT_LOAD,
`endif
   output logic [NUM_DOMAINS-1:0] DOMAIN_RESETn,
   output logic                   RESET_DONE,
   output logic [4:0]             RST_CAUSE
);

   localparam int IDX_W = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_DOMAINS - 1);
   localparam logic [7:0]       STRETCH_C = 8'(STRETCH);

   generate
      if (NUM_DOMAINS < 1 || NUM_DOMAINS > 8 || STRETCH < 1 || STRETCH > 255 ||
          SYNC_STAGES < 2 || SYNC_STAGES > 4 || WDT_WIDTH < 1) begin : g_bad_param
         $error("cm3_reset_seq: parameter out of range");
      end
   endgenerate

   typedef enum logic [1:0] {
      ST_HOLD = 2'd0,
      ST_STEP = 2'd1,
      ST_RUN  = 2'd2
   } state_t;

   state_t                   state_q, state_d;
   logic [7:0]               cnt_q, cnt_d;
   logic [IDX_W-1:0]         idx_q, idx_d;
   logic [NUM_DOMAINS-1:0]   dom_q, dom_d;
   logic                     done_q, done_d;
   logic [4:0]               cause_q, cause_d;
   logic [SYNC_STAGES-1:0]   sync_q, sync_d;
   logic                     ext_trig;
   logic                     wdt_expire;
   logic                     trig;

   // Pin enters at bit 0; the oldest stage drives the request
   assign sync_d   = {sync_q[SYNC_STAGES-2:0], EXT_RESETn};
   assign ext_trig = ~sync_q[SYNC_STAGES-1];

`ifdef CM3_RST_WDT_EN
   logic [WDT_WIDTH-1:0] wdt_cnt_q, wdt_cnt_d;
   logic                 wdt_armed_q, wdt_armed_d;
   logic                 wdt_en_prev_q, wdt_en_prev_d;
   logic                 wdt_in_run;
   logic                 wdt_reload;

   assign wdt_in_run = (state_q == ST_RUN);
   assign wdt_expire = wdt_in_run & WDT_EN & wdt_armed_q & (wdt_cnt_q == '0);
   assign wdt_reload = (WDT_EN & ~wdt_en_prev_q) | (WDT_KICK & WDT_EN & wdt_armed_q);

   always_comb begin
      wdt_cnt_d     = wdt_cnt_q;
      wdt_armed_d   = wdt_armed_q;
      wdt_en_prev_d = WDT_EN;
      if (wdt_expire) begin
         // One-shot: only a fresh enable edge re-arms
         wdt_armed_d = 1'b0;
      end else if (wdt_reload) begin
         wdt_cnt_d   = WDT_LOAD;
         wdt_armed_d = 1'b1;
      end else if (!wdt_in_run) begin
         wdt_cnt_d = WDT_LOAD;
      end else if (wdt_cnt_q != '0) begin
         wdt_cnt_d = wdt_cnt_q - 1'b1;
      end
   end

   always_ff @(posedge CLK) begin
      if (PORESET) begin
         wdt_cnt_q     <= '0;
         wdt_armed_q   <= 1'b0;
         wdt_en_prev_q <= 1'b0;
      end else begin
         wdt_cnt_q     <= wdt_cnt_d;
         wdt_armed_q   <= wdt_armed_d;
         wdt_en_prev_q <= wdt_en_prev_d;
      end
   end
`else
   assign wdt_expire = 1'b0;
`endif

   assign trig = ext_trig | SYSRESETREQ | SWRESET_REQ | wdt_expire;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      dom_d   = dom_q;
      done_d  = done_q;
      if (trig) begin
         state_d = ST_HOLD;
         cnt_d   = STRETCH_C;
         idx_d   = '0;
         dom_d   = '0;
         done_d  = 1'b0;
      end else begin
         case (state_q)
            ST_HOLD: begin
               if (cnt_q == 8'd0) begin
                  for (int i = 0; i < NUM_DOMAINS; i++) begin
                     if (idx_q == IDX_W'(i)) dom_d[i] = 1'b1;
                  end
                  if (idx_q == LAST_IDX) begin
                     state_d = ST_RUN;
                     done_d  = 1'b1;
                  end else begin
                     state_d = ST_STEP;
                  end
               end else begin
                  cnt_d = cnt_q - 1'b1;
               end
            end
            ST_STEP: begin
               idx_d   = idx_q + 1'b1;
               cnt_d   = STRETCH_C;
               state_d = ST_HOLD;
            end
            ST_RUN: begin
               done_d = 1'b1;
            end
            default: begin
               state_d = ST_HOLD;
               cnt_d   = STRETCH_C;
               idx_d   = '0;
               dom_d   = '0;
               done_d  = 1'b0;
            end
         endcase
      end
   end

   // A set request outranks a clear arriving in the same cycle
   always_comb begin
      cause_d = (CAUSE_CLR ? 5'b00000 : cause_q) |
                {wdt_expire, SWRESET_REQ, SYSRESETREQ, ext_trig, 1'b0};
   end

   always_ff @(posedge CLK) begin
      if (PORESET) begin
         state_q <= ST_HOLD;
         cnt_q   <= STRETCH_C;
         idx_q   <= '0;
         dom_q   <= '0;
         done_q  <= 1'b0;
         cause_q <= 5'b00001;
         sync_q  <= '1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         dom_q   <= dom_d;
         done_q  <= done_d;
         cause_q <= cause_d;
         sync_q  <= sync_d;
      end
   end

   assign DOMAIN_RESETn = dom_q;
   assign RESET_DONE    = done_q;
   assign RST_CAUSE     = cause_q;

endmodule
